// File: rtl/control_pkg.sv
// Shared encodings for the registered control decoder: condition codes, opcode
// classes, function fields, ALU/immediate selects, FSM states and the control word.
package control_pkg;

  localparam logic [3:0] CC_EQ = 4'd0,  CC_NE = 4'd1,  CC_CS = 4'd2,  CC_CC = 4'd3;
  localparam logic [3:0] CC_MI = 4'd4,  CC_PL = 4'd5,  CC_VS = 4'd6,  CC_VC = 4'd7;
  localparam logic [3:0] CC_HI = 4'd8,  CC_LS = 4'd9,  CC_GE = 4'd10, CC_LT = 4'd11;
  localparam logic [3:0] CC_GT = 4'd12, CC_LE = 4'd13, CC_AL = 4'd14;

  localparam logic [1:0] OP_DP = 2'd0, OP_MEM = 2'd1, OP_BR = 2'd2;

  localparam logic [3:0] FN_MUL = 4'd0, FN_SUB = 4'd2, FN_ADD = 4'd4;
  localparam logic [3:0] FN_ORR = 4'd12, FN_SHIFT = 4'd13;

  localparam logic [2:0] ALU_ADD = 3'd0, ALU_SUB = 3'd1, ALU_MUL = 3'd2, ALU_ORR = 3'd3;
  localparam logic [2:0] ALU_LSL = 3'd4, ALU_LSR = 3'd5, ALU_ASR = 3'd6, ALU_ROR = 3'd7;

  localparam logic [1:0] IMM_NONE = 2'd0, IMM_MEM = 2'd1, IMM_BR = 2'd2;

  typedef enum logic {RUN, MUL_WAIT} state_e;

  typedef struct packed {
    logic       alu_set;
    logic       sel_pc;
    logic       sel_dir_a;
    logic       reg_wr;
    logic       sel_b;
    logic       mem_wr;
    logic       sel_wb;
    logic       sel_dest;
    logic [1:0] imm_src;
    logic [2:0] alu_ctrl;
  } ctrl_t;

endpackage

// File: rtl/control_pipe_cond_eval.sv
// Combinational condition-code check against NZCV (bit0 Z, bit1 N, bit2 C, bit3 V).
module cond_eval (
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       enable
);
  logic z, n, c, v, base;

  assign {v, c, n, z} = flags;

  // Codes come in pairs; the odd member is the inverse of the even one.
  always_comb begin
    base = 1'b1;
    case (cond[3:1])
      3'd0:    base = z;
      3'd1:    base = c;
      3'd2:    base = n;
      3'd3:    base = v;
      3'd4:    base = !z & c;
      3'd5:    base = (n == v);
      3'd6:    base = !z & (n == v);
      default: base = 1'b1;
    endcase
    enable = (cond[3:1] == 3'd7) ? 1'b1 : (base ^ cond[0]);
  end
endmodule

// File: rtl/control_pipe.sv
// Registered control decoder with NZCV flag register, flag forwarding and a
// multiply issue stall; one bundle per valid/ready handshake, latency 1.
module control_pipe
  import control_pkg::*;
#(
  parameter int MUL_LAT    = 3,
  parameter int ALU_CTRL_W = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            cond,
  input  logic [1:0]            op,
  input  logic [5:0]            funct,
  input  logic [1:0]            sh,
  input  logic                  flags_valid,
  input  logic [3:0]            alu_flags,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  alu_set,
  output logic                  sel_pc,
  output logic                  sel_dir_a,
  output logic                  reg_wr,
  output logic                  sel_b,
  output logic                  mem_wr,
  output logic                  sel_wb,
  output logic                  sel_dest,
  output logic [1:0]            imm_src,
  output logic [ALU_CTRL_W-1:0] alu_ctrl,
  output logic [3:0]            flags_q,
  output logic                  busy
);
  localparam int CNT_W = (MUL_LAT > 2) ? $clog2(MUL_LAT - 1) : 1;
  localparam logic [CNT_W-1:0] MUL_INIT = CNT_W'((MUL_LAT > 1) ? MUL_LAT - 2 : 0);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  ctrl_t            word_q, word_d;
  logic             out_valid_q;
  logic [3:0]       eff_flags;
  logic             cond_ok, accept, is_mul;

  assign eff_flags = flags_valid ? alu_flags : flags_q;

  cond_eval u_cond (.cond(cond), .flags(eff_flags), .enable(cond_ok));

  assign in_ready = !rst && (state_q == RUN) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign busy     = (state_q == MUL_WAIT);

  always_comb begin
    word_d = '0;
    is_mul = 1'b0;
    if (cond_ok) begin
      case (op)
        OP_DP: begin
          word_d.reg_wr   = 1'b1;
          word_d.sel_dest = 1'b1;
          word_d.alu_set  = funct[0];
          word_d.sel_b    = funct[5];
          case (funct[4:1])
            FN_MUL: begin
              word_d.alu_ctrl  = ALU_MUL;
              word_d.sel_dir_a = 1'b1;
              is_mul           = 1'b1;
            end
            FN_SUB:   word_d.alu_ctrl = ALU_SUB;
            FN_ADD:   word_d.alu_ctrl = ALU_ADD;
            FN_ORR:   word_d.alu_ctrl = ALU_ORR;
            FN_SHIFT: word_d.alu_ctrl = ALU_LSL | {1'b0, sh};
            default:  word_d = '0;
          endcase
        end
        OP_MEM: begin
          if (funct[2]) begin
            word_d.imm_src  = IMM_MEM;
            word_d.sel_b    = funct[5];
            word_d.sel_dest = 1'b1;
            word_d.alu_ctrl = ALU_ADD;
            if (funct[0]) begin
              word_d.reg_wr = 1'b1;
              word_d.sel_wb = 1'b1;
            end else begin
              word_d.mem_wr = 1'b1;
            end
          end
        end
        OP_BR: begin
          word_d.sel_pc  = 1'b1;
          word_d.imm_src = IMM_BR;
        end
        default: word_d = '0;
      endcase
    end
  end

  // Counter holds the remaining stall cycles after the first one.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RUN: begin
        if (accept && is_mul && (MUL_LAT > 1)) begin
          state_d = MUL_WAIT;
          cnt_d   = MUL_INIT;
        end
      end
      MUL_WAIT: begin
        if (cnt_q == '0) state_d = RUN;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      cnt_q       <= '0;
      word_q      <= '0;
      out_valid_q <= 1'b0;
      flags_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (flags_valid) flags_q <= alu_flags;
      if (accept) begin
        word_q      <= word_d;
        out_valid_q <= 1'b1;
      end else if (out_ready) begin
        word_q      <= '0;
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign alu_set   = word_q.alu_set;
  assign sel_pc    = word_q.sel_pc;
  assign sel_dir_a = word_q.sel_dir_a;
  assign reg_wr    = word_q.reg_wr;
  assign sel_b     = word_q.sel_b;
  assign mem_wr    = word_q.mem_wr;
  assign sel_wb    = word_q.sel_wb;
  assign sel_dest  = word_q.sel_dest;
  assign imm_src   = word_q.imm_src;
  assign alu_ctrl  = ALU_CTRL_W'(word_q.alu_ctrl);
endmodule

// File: tb/tb_control_pipe.sv
// Self-checking bench: vector table, randomized traffic against a reference
// model, and hand-written stall / hold / reset sequences.
module tb_control_pipe;
  localparam int MUL_LAT = 3;
  localparam int ACW = 3;

  logic clk = 1'b0;
  logic rst, in_valid, in_ready, flags_valid, out_valid, out_ready;
  logic [3:0] cond, alu_flags, flags_q;
  logic [1:0] op, sh, imm_src;
  logic [5:0] funct;
  logic alu_set, sel_pc, sel_dir_a, reg_wr, sel_b, mem_wr, sel_wb, sel_dest, busy;
  logic [ACW-1:0] alu_ctrl;
  logic [12:0] dut_word;

  always #5 clk = ~clk;

  control_pipe #(.MUL_LAT(MUL_LAT), .ALU_CTRL_W(ACW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .cond(cond), .op(op), .funct(funct), .sh(sh),
    .flags_valid(flags_valid), .alu_flags(alu_flags),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_set(alu_set), .sel_pc(sel_pc), .sel_dir_a(sel_dir_a), .reg_wr(reg_wr),
    .sel_b(sel_b), .mem_wr(mem_wr), .sel_wb(sel_wb), .sel_dest(sel_dest),
    .imm_src(imm_src), .alu_ctrl(alu_ctrl), .flags_q(flags_q), .busy(busy)
  );

  assign dut_word = {alu_set, sel_pc, sel_dir_a, reg_wr, sel_b, mem_wr, sel_wb,
                     sel_dest, imm_src, alu_ctrl};

  int n_total = 0, n_pass = 0;
  logic        m_valid;
  logic [12:0] m_word;
  logic [3:0]  m_flags;
  int          blk;
  logic        s_ready, s_busy;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  function automatic bit ref_cond(input logic [3:0] c, input logic [3:0] fl);
    bit z, n, cy, v;
    z = fl[0]; n = fl[1]; cy = fl[2]; v = fl[3];
    case (c)
      0: return z;          1: return !z;
      2: return cy;         3: return !cy;
      4: return n;          5: return !n;
      6: return v;          7: return !v;
      8: return !z && cy;   9: return z || !cy;
      10: return n == v;    11: return n != v;
      12: return !z && (n == v);
      13: return z || (n != v);
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [12:0] ref_decode(input logic [3:0] c, input logic [1:0] o,
                                             input logic [5:0] f, input logic [1:0] s,
                                             input logic [3:0] fl);
    logic aset, pc, dira, rw, sb, mw, wb, dst;
    logic [1:0] imm;
    logic [2:0] alu;
    {aset, pc, dira, rw, sb, mw, wb, dst, imm, alu} = '0;
    if (!ref_cond(c, fl)) return '0;
    if (o == 2'd0) begin
      case (f[4:1])
        0: begin alu = 3'd2; dira = 1'b1; end
        2: alu = 3'd1;
        4: alu = 3'd0;
        12: alu = 3'd3;
        13: alu = 3'(4 + s);
        default: return '0;
      endcase
      rw = 1'b1; dst = 1'b1; aset = f[0]; sb = f[5];
    end else if (o == 2'd1) begin
      if (!f[2]) return '0;
      imm = 2'd1; sb = f[5]; dst = 1'b1;
      if (f[0]) begin rw = 1'b1; wb = 1'b1; end
      else mw = 1'b1;
    end else if (o == 2'd2) begin
      pc = 1'b1; imm = 2'd2;
    end else return '0;
    return {aset, pc, dira, rw, sb, mw, wb, dst, imm, alu};
  endfunction

  // One clock: check handshake at the falling edge, advance model, check registers.
  task automatic cycle();
    bit acc, mul_exec;
    logic [3:0] eff;
    logic [12:0] nw;
    @(negedge clk);
    s_ready = in_ready;
    s_busy  = busy;
    chk("in_ready", in_ready, (!rst && blk == 0 && (!m_valid || out_ready)));
    if (!rst) chk("busy", busy, blk != 0);
    acc = !rst && in_valid && blk == 0 && (!m_valid || out_ready);
    eff = flags_valid ? alu_flags : m_flags;
    nw  = ref_decode(cond, op, funct, sh, eff);
    mul_exec = (op == 2'd0) && (funct[4:1] == 4'd0) && ref_cond(cond, eff);
    @(posedge clk);
    if (rst) begin
      m_valid = 1'b0; m_word = '0; m_flags = '0; blk = 0;
    end else begin
      if (acc) begin m_valid = 1'b1; m_word = nw; end
      else if (out_ready) begin m_valid = 1'b0; m_word = '0; end
      if (flags_valid) m_flags = alu_flags;
      if (acc && mul_exec && MUL_LAT > 1) blk = MUL_LAT - 1;
      else if (blk > 0) blk--;
    end
    #1;
    chk("out_valid", out_valid, m_valid);
    chk("word", dut_word, m_word);
    chk("flags_q", flags_q, m_flags);
  endtask

  task automatic drive(input logic v, input logic [3:0] c, input logic [1:0] o,
                       input logic [5:0] f, input logic [1:0] s, input logic fv,
                       input logic [3:0] af, input logic ordy);
    in_valid = v; cond = c; op = o; funct = f; sh = s;
    flags_valid = fv; alu_flags = af; out_ready = ordy;
  endtask

  typedef struct {
    logic [3:0] c; logic [1:0] o; logic [5:0] f; logic [1:0] s;
    logic fv; logic [3:0] af; logic [12:0] exp;
  } vec_t;
  vec_t tbl[14];

  localparam logic [12:0] W_ADD = 13'b0_0_0_1_0_0_0_1_00_000;
  localparam logic [12:0] W_LDR = 13'b0_0_0_1_0_0_1_1_01_000;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{4'd14, 2'd0, 6'b001000, 2'd0, 1'b0, 4'b0000, W_ADD};
    tbl[1]  = '{4'd0,  2'd2, 6'b000000, 2'd0, 1'b1, 4'b0001, 13'b0_1_0_0_0_0_0_0_10_000};
    tbl[2]  = '{4'd0,  2'd2, 6'b000000, 2'd0, 1'b1, 4'b0000, 13'd0};
    tbl[3]  = '{4'd14, 2'd0, 6'b011010, 2'd2, 1'b0, 4'b0000, 13'b0_0_0_1_0_0_0_1_00_110};
    tbl[4]  = '{4'd14, 2'd0, 6'b111011, 2'd3, 1'b0, 4'b0000, 13'b1_0_0_1_1_0_0_1_00_111};
    tbl[5]  = '{4'd14, 2'd0, 6'b001010, 2'd0, 1'b0, 4'b0000, 13'd0};
    tbl[6]  = '{4'd14, 2'd1, 6'b000101, 2'd0, 1'b0, 4'b0000, W_LDR};
    tbl[7]  = '{4'd14, 2'd1, 6'b100100, 2'd0, 1'b0, 4'b0000, 13'b0_0_0_0_1_1_0_1_01_000};
    tbl[8]  = '{4'd14, 2'd1, 6'b000001, 2'd0, 1'b0, 4'b0000, 13'd0};
    tbl[9]  = '{4'd14, 2'd3, 6'b000000, 2'd0, 1'b0, 4'b0000, 13'd0};
    tbl[10] = '{4'd10, 2'd0, 6'b000101, 2'd0, 1'b1, 4'b1010, 13'b1_0_0_1_0_0_0_1_00_001};
    tbl[11] = '{4'd12, 2'd0, 6'b011000, 2'd0, 1'b1, 4'b0001, 13'd0};
    tbl[12] = '{4'd9,  2'd2, 6'b000000, 2'd0, 1'b1, 4'b0100, 13'd0};
    tbl[13] = '{4'd2,  2'd2, 6'b000000, 2'd0, 1'b0, 4'b0000, 13'b0_1_0_0_0_0_0_0_10_000};

    m_valid = 1'b0; m_word = '0; m_flags = '0; blk = 0;
    rst = 1'b1;
    drive(1'b0, 4'd0, 2'd0, 6'd0, 2'd0, 1'b0, 4'd0, 1'b1);
    cycle(); cycle();
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_flags", flags_q, 4'd0);
    rst = 1'b0;

    for (int i = 0; i < 14; i++) begin
      drive(1'b1, tbl[i].c, tbl[i].o, tbl[i].f, tbl[i].s, tbl[i].fv, tbl[i].af, 1'b1);
      cycle();
      chk($sformatf("vec%0d_word", i), dut_word, tbl[i].exp);
      chk($sformatf("vec%0d_valid", i), out_valid, 1'b1);
    end

    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 4'($urandom), 2'($urandom),
            ($urandom_range(0, 3) == 0) ? {1'($urandom), 4'd0, 1'($urandom)} : 6'($urandom),
            2'($urandom), 1'($urandom), 4'($urandom), 1'($urandom_range(0, 3) != 0));
      cycle();
    end

    // Multiply stall: MUL, then ADD held on the input until it is taken.
    drive(1'b0, 4'd14, 2'd0, 6'd0, 2'd0, 1'b0, 4'd0, 1'b1);
    for (int i = 0; i < MUL_LAT + 1; i++) cycle();
    drive(1'b1, 4'd14, 2'd0, 6'b000000, 2'd0, 1'b0, 4'd0, 1'b1);
    cycle();
    chk("mul_accepted", s_ready, 1'b1);
    drive(1'b1, 4'd14, 2'd0, 6'b001000, 2'd0, 1'b0, 4'd0, 1'b1);
    for (int i = 0; i < MUL_LAT - 1; i++) begin
      cycle();
      chk("mul_stall_busy", s_busy, 1'b1);
      chk("mul_stall_ready", s_ready, 1'b0);
    end
    cycle();
    chk("post_mul_ready", s_ready, 1'b1);
    chk("post_mul_add", dut_word, W_ADD);

    // LDR held four cycles with execute stalled.
    drive(1'b1, 4'd14, 2'd1, 6'b000101, 2'd0, 1'b0, 4'd0, 1'b1);
    cycle();
    drive(1'b1, 4'd14, 2'd0, 6'b001000, 2'd0, 1'b0, 4'd0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("hold_ready", s_ready, 1'b0);
      chk("hold_word", dut_word, W_LDR);
      chk("hold_valid", out_valid, 1'b1);
    end
    out_ready = 1'b1;
    cycle();
    chk("release_add", dut_word, W_ADD);

    // Reset in the middle of a multiply stall.
    drive(1'b1, 4'd14, 2'd0, 6'b000000, 2'd0, 1'b1, 4'hF, 1'b1);
    cycle();
    drive(1'b0, 4'd14, 2'd0, 6'd0, 2'd0, 1'b0, 4'd0, 1'b1);
    cycle();
    chk("pre_rst_busy", s_busy, 1'b1);
    rst = 1'b1;
    cycle();
    chk("rst_busy", busy, 1'b0);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_flags", flags_q, 4'd0);
    rst = 1'b0;
    cycle();
    chk("rst_ready", s_ready, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/control_pipe.md
# control_pipe

Registered, parametrised successor to the combinational control decoder. It accepts one instruction-field bundle per valid/ready handshake and decodes it into datapath control. It holds the architectural NZCV flag register, which the execute stage updates and which is forwarded on same-cycle updates. Multiply instructions stall issue for a parametrised number of cycles. It sits between fetch/decode field extraction and the execute stage.

## Interface
- MUL_LAT, 3, multiply occupancy in cycles (≥1); 1 means no stall
- ALU_CTRL_W, 3, width of alu_ctrl
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  instruction fields valid
- in_ready  out  1  block accepts fields this cycle
- cond  in  4  condition code
- op  in  2  opcode class
- funct  in  6  function field
- sh  in  2  shift type
- flags_valid  in  1  execute stage writes flags this cycle
- alu_flags  in  4  new flags; bit0 Z, bit1 N, bit2 C, bit3 V
- out_valid  out  1  registered control word valid
- out_ready  in  1  execute stage consumes control word
- alu_set, sel_pc, sel_dir_a, reg_wr, sel_b, mem_wr, sel_wb, sel_dest  out  1 each  control bits
- imm_src  out  2  immediate extension select
- alu_ctrl  out  ALU_CTRL_W  ALU operation
- flags_q  out  4  current flag register
- busy  out  1  multiply stall in progress

## Operation
- **Flag register**
  - flags_q loads alu_flags on every flags_valid cycle.
  - The condition check uses the effective flags: alu_flags when flags_valid is high in the accept cycle (forwarded), otherwise flags_q.
- **Condition codes**
  - 0 Z; 1 !Z; 2 C; 3 !C; 4 N; 5 !N; 6 V; 7 !V
  - 8 !Z&C; 9 Z|!C; 10 N==V; 11 N!=V; 12 !Z&(N==V); 13 Z|(N!=V); 14, 15 always
- **Failed condition:** the bundle is still accepted, but the control word is all zero (a NOP).
- **Default word:** every output is 0, then the fields below are overridden. No output ever holds a stale value.
- **op 0, data processing**
  - reg_wr=1, sel_dest=1, alu_set=funct[0], sel_b=funct[5].
  - funct[4:1]: 0 MUL (alu_ctrl 2, sel_dir_a 1); 2 SUB (1); 4 ADD (0); 12 ORR (3).
  - 13 shift, selected by sh: LSL 4, LSR 5, ASR 6, ROR 7.
  - Any other funct[4:1]: NOP word.
- **op 1, memory**
  - Requires funct[2]=1, otherwise NOP.
  - Common fields: imm_src=1, sel_b=funct[5], sel_dest=1, alu_ctrl=0.
  - funct[0]=0 STR: mem_wr=1.
  - funct[0]=1 LDR: reg_wr=1, sel_wb=1.
- **op 2, branch:** sel_pc=1, imm_src=2.
- **op 3:** NOP.
- **FSM**
  - RUN: in_ready = !out_valid | out_ready.
  - An executed MUL with MUL_LAT>1 moves the FSM to MUL_WAIT and loads the counter with MUL_LAT-2.
  - MUL_WAIT: in_ready=0, busy=1. The counter decrements each cycle; at 0 the FSM returns to RUN.
  - A MUL whose condition fails does not stall.

## Timing
- The control word is registered at the accept edge. out_valid rises the next cycle (latency 1).
- The output register holds while out_valid & !out_ready.
- out_valid clears on out_ready unless a new accept occurs in the same cycle.
- A MUL accepted at cycle t blocks accepts in cycles t+1 .. t+MUL_LAT-1. The next accept is possible at t+MUL_LAT.
- flags_valid and accept in the same cycle: the forwarded flags govern the condition, and flags_q updates at the same edge.
- **Reset**
  - flags_q=0, every control output=0, out_valid=0, busy=0, state RUN, counter=0.
  - in_ready=0 while rst is high.
  - Reset mid-stall abandons MUL_WAIT immediately.

## Structure
- control_pkg holds:
  - condition-code constants
  - op constants (DP, MEM, BR)
  - funct[4:1] constants (MUL, SUB, ADD, ORR, SHIFT)
  - alu_ctrl encodings 0–7
  - imm_src encodings
  - the FSM state enum
- Sub-module cond_eval: combinational; inputs cond and flags, output enable.

## Test plan
- Reset, then ADD (cond 14, op 0, funct 6'b001000) with out_ready=1 → next cycle out_valid=1, reg_wr=1, alu_ctrl=0, sel_b=0.
- flags_valid=1 with alu_flags=4'b0001 (Z) in the same cycle as a BEQ accept (cond 0, op 2) → sel_pc=1, imm_src=2. Repeat with Z=0 → all-zero word, out_valid=1.
- MUL with MUL_LAT=3 → in_ready=0 and busy=1 for exactly 2 cycles; a following ADD is accepted on the 3rd cycle.
- out_ready=0 for 4 cycles after an LDR → word held stable (reg_wr=1, sel_wb=1); in_ready=0 throughout.
- Shift with sh=2 → alu_ctrl=6. sh=3 → 7. funct[4:1]=5 → NOP word.
- Assert rst during MUL_WAIT → next cycle busy=0, out_valid=0, flags_q=0.
